// File: rtl/timer_alarm_ctrl_if.sv
// Signal bundle between the countdown timer / switch domain and the alarm controller.
// master = timer side (drives the inputs), slave = alarm controller.
interface timer_alarm_ctrl_if;
    logic       clk_1Hz;
    logic       set_n;
    logic       hold;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       ack_n;
    logic       buzzer;
    logic       blank;
    logic       alarm;
    logic [1:0] state_dbg;

    modport master (
        output clk_1Hz, set_n, hold, min_bcd, sec_bcd, ack_n,
        input  buzzer, blank, alarm, state_dbg
    );

    modport slave (
        input  clk_1Hz, set_n, hold, min_bcd, sec_bcd, ack_n,
        output buzzer, blank, alarm, state_dbg
    );
endinterface

// File: rtl/timer_alarm_ctrl.sv
// Alarm controller for the countdown timer: detects expiry to 00:00 and drives a pulsed
// buzzer and a 1 Hz display-blank flag until acknowledge, timeout or reload.
module timer_alarm_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned BEEP_HALF  = 12500000,
    parameter int unsigned ALARM_SECS = 30
) (
    input  logic         clk_50M,
    input  logic         rst_n,
    timer_alarm_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_ARMED    = 2'b01;
    localparam logic [1:0] S_ALARM    = 2'b10;
    localparam logic [1:0] S_SILENCED = 2'b11;

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned BEEP_W = $clog2(BEEP_HALF + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);
    localparam logic [7:0]        SECS_LAST = 8'(ALARM_SECS - 1);

    logic [1:0]        clk1_sync, set_sync, hold_sync, ack_sync, zero_sync;
    logic              zero_raw;
    logic              clk1_s, set_s, hold_s, ack_s, zero_s;
    logic              clk1_prev, tick;
    logic [DEB_W-1:0]  deb_cnt;
    logic              ack_stable, press;
    logic [1:0]        state, state_nx;
    logic              timeout;
    logic [BEEP_W-1:0] beep_cnt;
    logic [7:0]        tick_cnt;
    logic              buzzer_q, blank_q, alarm_q;

    assign zero_raw = (bus.min_bcd == 8'h00) && (bus.sec_bcd == 8'h00);
    assign clk1_s   = clk1_sync[1];
    assign set_s    = set_sync[1];
    assign hold_s   = hold_sync[1];
    assign ack_s    = ack_sync[1];
    assign zero_s   = zero_sync[1];

    // Two-flop synchronisers and the registered 1 Hz rising-edge tick.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            clk1_sync <= '0;
            set_sync  <= '0;
            hold_sync <= '0;
            ack_sync  <= '0;
            zero_sync <= '0;
            clk1_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
            clk1_sync <= {clk1_sync[0], bus.clk_1Hz};
            set_sync  <= {set_sync[0], bus.set_n};
            hold_sync <= {hold_sync[0], bus.hold};
            ack_sync  <= {ack_sync[0], bus.ack_n};
            zero_sync <= {zero_sync[0], zero_raw};
            clk1_prev <= clk1_s;
            tick      <= clk1_s & ~clk1_prev;
        end
    end

    // Stable value follows ack only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt    <= '0;
            ack_stable <= 1'b1;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (ack_s != ack_stable) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_cnt    <= '0;
                    ack_stable <= ack_s;
                    press      <= ~ack_s;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latch).
        state_nx = state;
        timeout  = tick && (tick_cnt == SECS_LAST);
        case (state)
            S_IDLE:     if (set_s && !hold_s && !zero_s) state_nx = S_ARMED;
            S_ARMED:    if (!set_s) state_nx = S_IDLE;
                        else if (zero_s) state_nx = S_ALARM;
            S_ALARM:    if (!set_s) state_nx = S_IDLE;
                        else if (press || timeout) state_nx = S_SILENCED;
            S_SILENCED: if (!set_s) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered off the next state so they move on the transition edge.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            beep_cnt <= '0;
            tick_cnt <= '0;
            buzzer_q <= 1'b0;
            blank_q  <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx == S_ALARM) begin
                alarm_q <= 1'b1;
                if (state != S_ALARM) begin
                    beep_cnt <= '0;
                    tick_cnt <= '0;
                    buzzer_q <= 1'b1;
                    blank_q  <= 1'b0;
                end else begin
                    if (beep_cnt == BEEP_LAST) begin
                        beep_cnt <= '0;
                        buzzer_q <= ~buzzer_q;
                    end else begin
                        beep_cnt <= beep_cnt + 1'b1;
                    end
                    if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        blank_q  <= ~blank_q;
                    end
                end
            end else begin
                beep_cnt <= '0;
                tick_cnt <= '0;
                buzzer_q <= 1'b0;
                blank_q  <= 1'b0;
                alarm_q  <= 1'b0;
            end
        end
    end

    assign bus.buzzer    = buzzer_q;
    assign bus.blank     = blank_q;
    assign bus.alarm     = alarm_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_timer_alarm_ctrl.sv
// Randomised bench for timer_alarm_ctrl against a cycle-level behavioural model built
// from input histories, elapsed-cycle and tick counts.
module tb_timer_alarm_ctrl;

    localparam int DEB = 4;
    localparam int BEEP = 3;
    localparam int SECS = 5;
    localparam int HZ_PERIOD = 40;

    typedef enum logic [1:0] {
        M_IDLE = 2'b00, M_ARMED = 2'b01, M_ALARM = 2'b10, M_SILENCED = 2'b11
    } mstate_t;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hz_cnt   = 0;

    timer_alarm_ctrl_if bus();

    timer_alarm_ctrl #(
        .DEB_CYCLES(DEB), .BEEP_HALF(BEEP), .ALARM_SECS(SECS)
    ) dut (
        .clk_50M(clk_50M),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_50M = ~clk_50M;

    // Reference model: raw-input histories (bit 0 = sample at the current edge).
    mstate_t    m_state;
    int         m_age, m_ticks, m_run;
    logic       m_stable, m_press;
    logic [4:0] h_set, h_hold, h_zero, h_ack, h_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_age    = 0;
        m_ticks  = 0;
        m_run    = 0;
        m_stable = 1'b1;
        m_press  = 1'b0;
        h_set = '0; h_hold = '0; h_zero = '0; h_ack = '0; h_clk = '0;
    endtask

    task automatic model_edge();
        logic press_now, tick, set_s, hold_s, zero_s;
        h_set  = {h_set[3:0], bus.set_n};
        h_hold = {h_hold[3:0], bus.hold};
        h_zero = {h_zero[3:0], (bus.min_bcd == 8'h00 && bus.sec_bcd == 8'h00)};
        h_ack  = {h_ack[3:0], bus.ack_n};
        h_clk  = {h_clk[3:0], bus.clk_1Hz};
        press_now = m_press;
        m_press   = 1'b0;
        if (h_ack[2] != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
                m_stable = h_ack[2];
                m_run    = 0;
                m_press  = !m_stable;
            end
        end else begin
            m_run = 0;
        end
        set_s  = h_set[2];
        hold_s = h_hold[2];
        zero_s = h_zero[2];
        tick   = h_clk[3] && !h_clk[4];
        case (m_state)
            M_IDLE:  if (set_s && !hold_s && !zero_s) m_state = M_ARMED;
            M_ARMED: begin
                if (!set_s) m_state = M_IDLE;
                else if (zero_s) begin
                    m_state = M_ALARM;
                    m_age   = 0;
                    m_ticks = 0;
                end
            end
            M_ALARM: begin
                if (!set_s) m_state = M_IDLE;
                else if (press_now || (tick && m_ticks + 1 == SECS)) m_state = M_SILENCED;
                else begin
                    m_age++;
                    if (tick) m_ticks++;
                end
            end
            default: if (!set_s) m_state = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        logic in_alarm;
        in_alarm = (m_state == M_ALARM);
        check("state", {6'b0, bus.state_dbg}, {6'b0, m_state});
        check("alarm", {7'b0, bus.alarm}, {7'b0, in_alarm});
        check("buzzer", {7'b0, bus.buzzer}, {7'b0, in_alarm && ((m_age / BEEP) % 2 == 0)});
        check("blank", {7'b0, bus.blank}, {7'b0, in_alarm && (m_ticks % 2 == 1)});
    endtask

    // One clk_50M cycle: inputs change at the falling edge, outputs are read 1 ns after the rise.
    task automatic cycle();
        hz_cnt = (hz_cnt + 1) % HZ_PERIOD;
        bus.clk_1Hz = (hz_cnt >= HZ_PERIOD / 2);
        @(posedge clk_50M);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        compare_all();
        @(negedge clk_50M);
    endtask

    task automatic run_until(input mstate_t target, input int limit, input string tag);
        int n;
        n = 0;
        while (m_state != target && n < limit) begin
            cycle();
            n++;
        end
        check(tag, {6'b0, bus.state_dbg}, {6'b0, target});
    endtask

    task automatic load(input logic [7:0] mn, input logic [7:0] sc);
        bus.set_n   = 1'b0;
        bus.min_bcd = mn;
        bus.sec_bcd = sc;
        repeat (4) cycle();
        bus.set_n = 1'b1;
    endtask

    function automatic logic [7:0] rnd_bcd();
        return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    endfunction

    task automatic expire();
        load(8'h00, 8'h01 + 8'($urandom_range(0, 8)));
        run_until(M_ARMED, 10, "arm");
        bus.sec_bcd = 8'h00;
        run_until(M_ALARM, 10, "expire");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] beep_pat;
        int n;
        beep_pat = 7'b1000111;
        bus.clk_1Hz = 1'b0; bus.set_n = 1'b0; bus.hold = 1'b0;
        bus.min_bcd = 8'h00; bus.sec_bcd = 8'h00; bus.ack_n = 1'b1;
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        check("idle_after_reset", {6'b0, bus.state_dbg}, 8'h00);

        // Expiry latency, buzzer cadence, then timeout and reload.
        load(8'h00, 8'h02);
        run_until(M_ARMED, 10, "arm_0002");
        bus.sec_bcd = 8'h01;
        repeat (3) cycle();
        bus.sec_bcd = 8'h00;
        repeat (2) cycle();
        check("zero_lat2", {7'b0, bus.alarm}, 8'h00);
        cycle();
        check("zero_lat3", {7'b0, bus.alarm}, 8'h01);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cycle();
            check("beep_pat", {7'b0, bus.buzzer}, {7'b0, beep_pat[i]});
        end
        run_until(M_SILENCED, 300, "timeout");
        check("timeout_buzzer", {7'b0, bus.buzzer}, 8'h00);
        bus.set_n = 1'b0;
        run_until(M_IDLE, 10, "timeout_reload");

        // Acknowledge: short glitch ignored, held press silences on the 7th edge.
        expire();
        bus.ack_n = 1'b0;
        repeat (2) cycle();
        bus.ack_n = 1'b1;
        repeat (10) cycle();
        check("glitch", {6'b0, bus.state_dbg}, 8'h02);
        bus.ack_n = 1'b0;
        repeat (6) cycle();
        check("press_lat6", {6'b0, bus.state_dbg}, 8'h02);
        cycle();
        check("press_lat7", {6'b0, bus.state_dbg}, 8'h03);
        cycle();
        bus.ack_n = 1'b1;
        repeat (8) cycle();

        // Press lined up around the timeout tick; offset 2 makes them coincide.
        for (int off = 0; off < 5; off++) begin
            expire();
            n = 0;
            while (!(m_state == M_ALARM && m_ticks == SECS - 1 && hz_cnt == 14 + off)
                   && n < 400) begin
                cycle();
                n++;
            end
            check("ack_tick_wait", {7'b0, n < 400}, 8'h01);
            bus.ack_n = 1'b0;
            repeat (8) cycle();
            bus.ack_n = 1'b1;
            run_until(M_SILENCED, 20, "ack_tick");
            repeat (6) cycle();
        end

        // Preset 00:00 never arms; hold keeps ARMED.
        load(8'h00, 8'h00);
        repeat (20) cycle();
        check("preset_zero", {6'b0, bus.state_dbg}, 8'h00);
        load(8'h00, 8'h07);
        run_until(M_ARMED, 10, "arm_0007");
        bus.hold = 1'b1;
        repeat (20) cycle();
        check("hold_armed", {6'b0, bus.state_dbg}, 8'h01);
        bus.hold = 1'b0;

        // Reload during alarm with ack also low: set wins within 3 cycles.
        expire();
        bus.set_n = 1'b0;
        bus.ack_n = 1'b0;
        repeat (2) cycle();
        check("set_lat2", {7'b0, bus.alarm}, 8'h01);
        cycle();
        check("set_lat3", {7'b0, bus.alarm}, 8'h00);
        check("set_idle", {6'b0, bus.state_dbg}, 8'h00);
        bus.ack_n = 1'b1;
        load(8'h01, 8'h00);
        run_until(M_ARMED, 10, "rearm_0100");

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: load(8'h00, ($urandom_range(0, 4) == 0) ? 8'h00 : rnd_bcd());
                1: begin bus.min_bcd = 8'h00; bus.sec_bcd = 8'h00; end
                2: begin
                    bus.ack_n = 1'b0;
                    repeat ($urandom_range(1, 10)) cycle();
                    bus.ack_n = 1'b1;
                end
                3: bus.hold = ~bus.hold;
                4: repeat ($urandom_range(1, 60)) cycle();
                default: begin
                    bus.set_n = 1'b0;
                    repeat ($urandom_range(1, 5)) cycle();
                    bus.set_n = 1'b1;
                end
            endcase
            repeat ($urandom_range(1, 20)) cycle();
        end
        bus.hold = 1'b0;

        // Asynchronous reset in the middle of an alarm.
        expire();
        repeat (5) cycle();
        bus.set_n = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (12) cycle();
        check("idle_after_mid_reset", {6'b0, bus.state_dbg}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
